// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: sequencer states, sizes and GF(2^8) byte helpers
// used to build the inverse S-box from arithmetic rather than a lookup table.
package aes_pkg;

  localparam int unsigned NR       = 10;
  localparam int unsigned RK_IDX_W = 4;
  localparam int unsigned BLK_W    = 128;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [BLK_W-1:0] key,
  input  logic             last,
  output logic [BLK_W-1:0] result
);

  logic [BLK_W-1:0] shifted;
  logic [BLK_W-1:0] subbed;
  logic [BLK_W-1:0] keyed;
  logic [BLK_W-1:0] mixed;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = gf_xtime(a[i]);
      x4    = gf_xtime(x2);
      x8    = gf_xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Byte 4*c+r sits at row r of column c; row r rotates right by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[BLK_W-1-8*(4*c+r) -: 8] = state[BLK_W-1-8*(4*((c-r+4)%4)+r) -: 8];
      assign subbed[BLK_W-1-8*(4*c+r) -: 8]  = inv_sbox(shifted[BLK_W-1-8*(4*c+r) -: 8]);
    end
    assign mixed[BLK_W-1-32*c -: 32] = inv_mix_col(keyed[BLK_W-1-32*c -: 32]);
  end

  assign keyed  = subbed ^ key;
  assign result = last ? keyed : mixed;

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption sequencer: initial key addition on accept, nine full inverse
// rounds, one final round, then holds the plaintext until the consumer takes it.
module aes_inv_round_ctrl #(
  parameter int unsigned NR       = 10,
  parameter int unsigned RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_data,
  input  logic                abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy,
  output logic [RK_IDX_W-1:0] round
);
  import aes_pkg::*;

  localparam logic [RK_IDX_W-1:0] RndFirst = RK_IDX_W'(NR);

  state_e              state_q, state_d;
  logic [RK_IDX_W-1:0] round_q, round_d;
  logic [BLK_W-1:0]    blk_q, blk_d;
  logic [BLK_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [BLK_W-1:0]    rnd_out;
  logic                last_rnd;

  assign last_rnd = (state_q == FINAL);

  aes_inv_round u_round (
    .state  (blk_q),
    .key    (rk_data),
    .last   (last_rnd),
    .result (rnd_out)
  );

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    blk_d       = blk_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready    = 1'b0;
    rk_idx      = round_q;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        rk_idx   = RndFirst;
        if (in_valid) begin
          blk_d   = in_data ^ rk_data;
          round_d = RndFirst - RK_IDX_W'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (abort) begin
          round_d = RndFirst;
          state_d = IDLE;
        end else begin
          blk_d = rnd_out;
          if (round_q == RK_IDX_W'(1)) begin
            round_d = '0;
            state_d = FINAL;
          end else begin
            round_d = round_q - RK_IDX_W'(1);
          end
        end
      end
      FINAL: begin
        rk_idx = '0;
        if (abort) begin
          round_d = RndFirst;
          state_d = IDLE;
        end else begin
          out_data_d  = rnd_out;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // abort and a normal handshake both retire the block; abort simply discards it
        if (abort || out_ready) begin
          out_valid_d = 1'b0;
          round_d     = RndFirst;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_q     <= RndFirst;
      blk_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      blk_q       <= blk_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign round     = round_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: byte-level AES reference decryption plus a cycle-count model
// of the handshake, compared on every falling edge, with FIPS-197 literal expectations.
module tb_aes_inv_round_ctrl;

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_data, out_data;
  logic [3:0]   rk_idx, round;

  logic [127:0] rk_tab [16];
  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  int           checks = 0;
  int           errors = 0;

  // model state: m_k counts edges since accept (1..9 rounds, 10 final, 11 holding output)
  int           cyc = 0;
  bit           m_act;
  int           m_k;
  logic [127:0] m_exp, m_out;
  int           acc_log [$];

  always #5 clk = ~clk;

  assign rk_data = rk_tab[rk_idx];

  aes_inv_round_ctrl #(.NR(10), .RK_IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round     (round)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [7:0] coef(input int k);
    case (k)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [127:0] decrypt(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] pt;
    logic [127:0] k;
    k = rk_tab[10];
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      k = rk_tab[r];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*c+w] = isbox[s[4*((c-w+4)%4)+w]] ^ k[127-8*(4*c+w) -: 8];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) begin
          s[4*c+w] = t[4*c+w];
          if (r > 0) begin
            s[4*c+w] = 8'h00;
            for (int j = 0; j < 4; j++) s[4*c+w] = s[4*c+w] ^ gmul(t[4*c+j], coef((j-w+4)%4));
          end
        end
    end
    for (int i = 0; i < 16; i++) pt[127-8*i -: 8] = s[i];
    return pt;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_k   <= 0;
      m_out <= '0;
    end else begin
      if (!m_act) begin
        if (in_valid) begin
          m_act <= 1'b1;
          m_k   <= 1;
          m_exp <= decrypt(in_data);
          acc_log.push_back(cyc);
        end
      end else if (m_k <= 10) begin
        if (abort) m_act <= 1'b0;
        else begin
          if (m_k == 10) m_out <= m_exp;
          m_k <= m_k + 1;
        end
      end else if (abort || out_ready) begin
        m_act <= 1'b0;
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("in_ready", 128'(in_ready), 128'(!m_act));
      chk("busy", 128'(busy), 128'(m_act));
      chk("out_valid", 128'(out_valid), 128'(m_act && m_k == 11));
      chk("out_data", out_data, m_out);
      if (!m_act) begin
        chk("rk_idx_idle", 128'(rk_idx), 128'(10));
        chk("round_idle", 128'(round), 128'(10));
      end else if (m_k <= 10) begin
        chk("rk_idx", 128'(rk_idx), 128'(10 - m_k));
        chk("round", 128'(round), 128'(10 - m_k));
      end else begin
        chk("round_done", 128'(round), 128'(0));
      end
    end
  end

  task automatic send(input logic [127:0] ct);
    int n;
    n = acc_log.size();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = ct;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (acc_log.size() > n) break;
    end
    in_valid = 1'b0;
    chk("accept", 128'(acc_log.size()), 128'(n + 1));
  endtask

  task automatic wait_out(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk(nm, 128'(out_valid), 128'(1));
  endtask

  task automatic wait_k(input int k);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_act && m_k == k) break;
    end
    chk("wait_k", 128'(m_k), 128'(k));
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [43:0] seq;
    logic [7:0]  xb, inv;
    bit          seen;
    int          n0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = affine(inv);
    end
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    expand(KeyB);
    chk("model_rk10", rk_tab[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_pt_b", decrypt(CtB), PtB);

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_data", out_data, 128'h0);

    // App. B: rk_idx sequence, latency, then 20 cycles of backpressure
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = CtB;
    @(negedge clk); seq = 44'(rk_idx);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seq = {seq[39:0], rk_idx};
    end
    chk("rk_seq", 128'(seq), 128'h0a9876543210);
    wait_out("b_valid");
    chk("b_latency", 128'(cyc - acc_log[$]), 128'(11));
    chk("b_pt", out_data, PtB);
    repeat (20) @(negedge clk);
    chk("bp_valid", 128'(out_valid), 128'(1));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_data", out_data, PtB);
    pulse_ready();
    @(negedge clk);
    chk("bp_release", 128'(in_ready), 128'(1));

    // App. C
    expand(KeyC);
    chk("model_pt_c", decrypt(CtC), PtC);
    send(CtC);
    wait_out("c_valid");
    chk("c_pt", out_data, PtC);
    pulse_ready();

    // back-to-back with in_valid held and out_ready high
    out_ready = 1'b1;
    n0 = acc_log.size();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = CtC;
    for (int i = 0; i < 40 && acc_log.size() <= n0; i++) @(negedge clk);
    in_data = CtB;
    wait_out("b2b_first");
    chk("b2b_pt1", out_data, PtC);
    for (int i = 0; i < 40 && acc_log.size() <= n0 + 1; i++) @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_accepts", 128'(acc_log.size()), 128'(n0 + 2));
    chk("b2b_gap", 128'(acc_log[n0+1] - acc_log[n0]), 128'(12));
    wait_out("b2b_second");
    @(posedge clk); #1 out_ready = 1'b0;

    // abort at round 5, then a clean block
    send(CtC);
    wait_k(5);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 128'(in_ready), 128'(1));
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort_no_valid", 128'(seen), 128'(0));
    send(CtC);
    wait_out("after_abort_valid");
    chk("after_abort_pt", out_data, PtC);

    // abort in DONE takes priority over out_ready
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("abort_done_valid", 128'(out_valid), 128'(0));
    chk("abort_done_ready", 128'(in_ready), 128'(1));
    chk("abort_done_data", out_data, PtC);

    // asynchronous reset between edges, mid-round
    send(CtC);
    wait_k(4);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_round", 128'(round), 128'(10));
    chk("arst_data", out_data, 128'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", 128'(in_ready), 128'(1));
    chk("arst_busy_after", 128'(busy), 128'(0));
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("arst_no_output", 128'(seen), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_inv_round_ctrl.md
Name: aes_inv_round_ctrl

Overview:
Iterative AES-128 decryption sequencer that drives one shared inverse-round datapath (InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns) over 11 key-addition steps. It accepts one ciphertext block through a valid/ready handshake and requests round keys by index from the external key-schedule store. It returns the plaintext through a valid/ready handshake. It sits between the block-cipher front end and the existing byte-parallel inverse S-box stage, and is the only block that sequences that stage.

Parameters:
NR, 10, number of AES rounds (AES-128 only; other values unsupported)
RK_IDX_W, 4, width of round-key index

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  ciphertext block valid
in_ready  out  1  block can be accepted
in_data  in  128  ciphertext; byte 0 in [127:120]
rk_idx  out  RK_IDX_W  round-key index requested; key must be returned combinationally in the same cycle
rk_data  in  128  round key for rk_idx
abort  in  1  synchronous abort of an in-flight block
out_valid  out  1  plaintext valid
out_ready  in  1  downstream accepts plaintext
out_data  out  128  plaintext
busy  out  1  high in ROUND, FINAL or DONE
round  out  RK_IDX_W  current round counter (debug)

Behaviour:
- States: IDLE, ROUND, FINAL, DONE. Reset (async, rst=1): state=IDLE, round=NR, state_reg=0, out_valid=0, out_data=0, busy=0; in_ready=1 once rst deasserts.
- IDLE: in_ready=1, rk_idx=NR. On in_valid&&in_ready, state_reg <= in_data ^ rk_data (initial AddRoundKey), round <= NR-1, go to ROUND.
- ROUND (round 9..1): rk_idx=round. state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_data). round decrements. When round==1, go to FINAL with round <= 0.
- FINAL: rk_idx=0. out_data <= InvSubBytes(InvShiftRows(state_reg)) ^ rk_data, out_valid <= 1, go to DONE.
- DONE: out_valid=1, out_data held stable. On out_ready, out_valid <= 0, round <= NR, go to IDLE. in_ready stays 0 in DONE; there is no same-cycle turnaround.
- Latency: accept at cycle T gives out_valid high from cycle T+11. Throughput is one block per 12 cycles, or more if backpressured.
- in_ready is 0 in every state except IDLE. in_valid and in_data are ignored while in_ready=0.
- rk_idx is a registered-state decode and is stable for the whole cycle. rk_data is sampled only on the state-advancing edge.
- abort: in ROUND or FINAL, the next state is IDLE, round=NR, out_valid stays 0, and out_data is unchanged. In DONE, abort drops out_valid and returns to IDLE, discarding the block. abort has no effect in IDLE. abort has priority over out_ready.
- out_ready while out_valid=0 is ignored.
- rst asserted mid-operation immediately forces the reset values. No partial output may appear afterwards.
- All byte ordering follows the FIPS-197 column-major state: bytes [127:120],[119:112],[111:104],[103:96] form column 0.

Decomposition:
- Shared package aes_pkg: state enum constants (IDLE, ROUND, FINAL, DONE), NR=10, RK_IDX_W, block width 128.
- One combinational sub-module, aes_inv_round. Inputs: state, key, last flag. Output: the next state. It instantiates InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, and bypasses InvMixColumns when last=1.
- The controller holds only the FSM, the round counter and the state/output registers.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, bench supplies the expanded keys by rk_idx, ct 3925841d02dc09fbdc118597196a0b32 -> out_data 3243f6a8885a308d313198a2e0370734, out_valid rises exactly 11 cycles after accept; rk_idx sequence is 10,9,...,0.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_data stable, in_ready=0 throughout; one out_ready pulse -> IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with two vectors -> second accepted exactly 12 cycles after the first, both results correct.
- Abort at round 5 -> IDLE next cycle, out_valid never asserts; a following block decrypts correctly. Abort in DONE -> out_valid drops, no handshake completes.
- Async reset pulsed mid-ROUND between clock edges -> outputs go to reset values immediately; busy=0, in_ready=1 after release.
